// File: rtl/alu_pipelined_if.sv
// -----------------------------------------------------------------------------
// alu_pipelined_if
// Handshake/data bundle between an operation producer and the pipelined ALU.
//
// Signals
//   Enable      producer -> ALU   block enable (0 stops new acceptance)
//   In_Valid    producer -> ALU   Data_A/Data_B/Opcode valid
//   In_Ready    ALU -> producer   ALU accepts an operation this cycle
//   Data_A      producer -> ALU   operand A
//   Data_B      producer -> ALU   operand B or shift amount
//   Opcode      producer -> ALU   operation select
//   Out_Valid   ALU -> consumer   Results and flags valid
//   Out_Ready   consumer -> ALU   consumer takes the result this cycle
//   Results     ALU -> consumer   registered result
//   CF/ZF/NF/VF ALU -> consumer   carry/borrow, zero, negative, overflow
//
// Modports: master = side that issues operations and consumes results,
//           slave  = the ALU itself.
// -----------------------------------------------------------------------------
interface alu_pipelined_if #(
    parameter int WIDTH = 16
) ();
    logic             Enable;
    logic             In_Valid;
    logic             In_Ready;
    logic [WIDTH-1:0] Data_A;
    logic [WIDTH-1:0] Data_B;
    logic [3:0]       Opcode;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [WIDTH-1:0] Results;
    logic             CF;
    logic             ZF;
    logic             NF;
    logic             VF;

    modport master (
        output Enable, In_Valid, Data_A, Data_B, Opcode, Out_Ready,
        input  In_Ready, Out_Valid, Results, CF, ZF, NF, VF
    );

    modport slave (
        input  Enable, In_Valid, Data_A, Data_B, Opcode, Out_Ready,
        output In_Ready, Out_Valid, Results, CF, ZF, NF, VF
    );
endinterface

// File: rtl/alu_pipelined.sv
// -----------------------------------------------------------------------------
// alu_pipelined
// Two-stage valid/ready ALU. Stage 1 captures the operands, stage 2 holds the
// executed result plus CF/ZF/NF/VF. Without back-pressure an accepted op shows
// up on Out_Valid two clock edges later; throughput is one op per cycle.
//
// Ports
//   CLK   clock, all state changes on the rising edge
//   RST   asynchronous active-low reset
//   bus   alu_pipelined_if.slave (see interface file for signal list)
//
// Parameters
//   WIDTH operand/result width (4..64); must match the interface instance
//   SHW   number of Data_B LSBs used as shift amount
// -----------------------------------------------------------------------------
module alu_pipelined #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              CLK,
    input  logic              RST,
    alu_pipelined_if.slave    bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_ADC  = 4'h9;
    localparam logic [3:0] OP_SBB  = 4'hA;
    localparam logic [3:0] OP_INC  = 4'hB;
    localparam logic [3:0] OP_DEC  = 4'hC;
    localparam logic [3:0] OP_PASS = 4'hD;
    localparam logic [3:0] OP_CMP  = 4'hE;

    // ---------------- stage registers ----------------
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [3:0]       s1_op_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] res_q;
    logic             cf_q;
    logic             zf_q;
    logic             nf_q;
    logic             vf_q;

    // ---------------- handshake ----------------
    logic s2_adv;
    logic s1_adv;
    logic in_ready;
    logic accept;

    assign s2_adv   = !s2_valid_q || bus.Out_Ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    // RST is folded in so the block never advertises readiness while held in
    // reset; it does not depend on In_Valid.
    assign in_ready = RST && bus.Enable && (!s1_valid_q || s1_adv);
    assign accept   = bus.In_Valid && in_ready;

    assign bus.In_Ready  = in_ready;
    assign bus.Out_Valid = s2_valid_q;
    assign bus.Results   = res_q;
    assign bus.CF        = cf_q;
    assign bus.ZF        = zf_q;
    assign bus.NF        = nf_q;
    assign bus.VF        = vf_q;

    // ---------------- execute (between S1 and S2) ----------------
    logic [WIDTH-1:0]  add_op2;
    logic              add_ci;
    logic [WIDTH:0]    add_ext;
    logic              add_v;
    logic [WIDTH-1:0]  sub_op2;
    logic              sub_bi;
    logic [WIDTH:0]    sub_ext;
    logic              sub_v;
    logic [SHW-1:0]    sh_amt;
    logic [WIDTH:0]    shl_ext;
    logic [WIDTH:0]    shr_ext;
    logic signed [WIDTH:0] sra_ext;

    logic [WIDTH-1:0]  res_d;
    logic              cf_d;
    logic              zf_d;
    logic              nf_d;
    logic              vf_d;

    always_comb begin
        // Carry/borrow-in for ADC/SBB is the CF of the op most recently
        // loaded into S2; cf_q only changes on such a load (or reset), so it
        // is exactly that value, including for back-to-back chains.
        add_op2 = (s1_op_q == OP_INC) ? {{(WIDTH-1){1'b0}}, 1'b1} : s1_b_q;
        add_ci  = (s1_op_q == OP_ADC) ? cf_q : 1'b0;
        add_ext = {1'b0, s1_a_q} + {1'b0, add_op2} + {{WIDTH{1'b0}}, add_ci};
        add_v   = (s1_a_q[MSB] == add_op2[MSB]) && (add_ext[MSB] != s1_a_q[MSB]);

        sub_op2 = (s1_op_q == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : s1_b_q;
        sub_bi  = (s1_op_q == OP_SBB) ? cf_q : 1'b0;
        // Top bit of the extended difference is the borrow out.
        sub_ext = {1'b0, s1_a_q} - {1'b0, sub_op2} - {{WIDTH{1'b0}}, sub_bi};
        sub_v   = (s1_a_q[MSB] != sub_op2[MSB]) && (sub_ext[MSB] != s1_a_q[MSB]);

        // Extended shifts keep the last bit shifted out in the extra bit;
        // with a zero shift amount that bit is 0.
        sh_amt  = s1_b_q[SHW-1:0];
        shl_ext = {1'b0, s1_a_q} << sh_amt;
        shr_ext = {s1_a_q, 1'b0} >> sh_amt;
        sra_ext = $signed({s1_a_q, 1'b0}) >>> sh_amt;

        res_d = '0;
        cf_d  = 1'b0;
        vf_d  = 1'b0;
        case (s1_op_q)
            OP_ADD, OP_ADC, OP_INC: begin
                res_d = add_ext[MSB:0];
                cf_d  = add_ext[WIDTH];
                vf_d  = add_v;
            end
            OP_SUB, OP_SBB, OP_DEC: begin
                res_d = sub_ext[MSB:0];
                cf_d  = sub_ext[WIDTH];
                vf_d  = sub_v;
            end
            OP_CMP: begin
                res_d = s1_a_q;
                cf_d  = sub_ext[WIDTH];
                vf_d  = sub_v;
            end
            OP_AND:  res_d = s1_a_q & s1_b_q;
            OP_OR:   res_d = s1_a_q | s1_b_q;
            OP_XOR:  res_d = s1_a_q ^ s1_b_q;
            OP_NOT:  res_d = ~s1_a_q;
            OP_PASS: res_d = s1_b_q;
            OP_SHL: begin
                res_d = shl_ext[MSB:0];
                cf_d  = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res_d = shr_ext[WIDTH:1];
                cf_d  = shr_ext[0];
            end
            OP_SRA: begin
                res_d = sra_ext[WIDTH:1];
                cf_d  = sra_ext[0];
            end
            default: begin
                // Reserved opcode retires with zero result and all flags clear.
                res_d = '0;
                cf_d  = 1'b0;
                vf_d  = 1'b0;
            end
        endcase

        // CMP reports Z/N of the difference while passing A through.
        if (s1_op_q == OP_CMP) begin
            zf_d = (sub_ext[MSB:0] == '0);
            nf_d = sub_ext[MSB];
        end else if (s1_op_q == 4'hF) begin
            zf_d = 1'b0;
            nf_d = 1'b0;
        end else begin
            zf_d = (res_d == '0);
            nf_d = res_d[MSB];
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            cf_q       <= 1'b0;
            zf_q       <= 1'b0;
            nf_q       <= 1'b0;
            vf_q       <= 1'b0;
        end else begin
            // Stage 1: a new op overwrites only when the old one leaves.
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= bus.Data_A;
                s1_b_q     <= bus.Data_B;
                s1_op_q    <= bus.Opcode;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            // Stage 2: result and flags only change when an op moves in, so
            // they stay stable under back-pressure and across bubbles.
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q <= res_d;
                    cf_q  <= cf_d;
                    zf_q  <= zf_d;
                    nf_q  <= nf_d;
                    vf_q  <= vf_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_pipelined.sv
// -----------------------------------------------------------------------------
// tb_alu_pipelined
// Directed plus randomised stimulus for alu_pipelined (WIDTH = 16). Expected
// results are pushed to a scoreboard queue when an op is accepted and popped
// when the DUT hands a result over; outputs are sampled 1 ns after the falling
// edge, inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_pipelined;
    localparam int W = 16;

    typedef struct packed {
        logic [15:0] res;
        logic        cf;
        logic        zf;
        logic        nf;
        logic        vf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_pipelined_if #(.WIDTH(W)) ifc ();

    alu_pipelined #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (ifc)
    );

    exp_t sb_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   acc_cnt = 0;
    logic model_cf = 1'b0;
    bit   held_v   = 1'b0;
    exp_t held;

    // Independent reference: integer arithmetic, bit-by-bit shifts.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic cin);
        exp_t        e;
        int          ua, ub, sa, sb, ci, t, st;
        logic [15:0] r;
        logic        c;
        bit          arith, is_sub;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = cin ? 1 : 0;
        t = 0; st = 0; arith = 0; is_sub = 0; r = '0; c = 1'b0;
        e = '0;
        case (op)
            4'h0: begin t = ua + ub;      st = sa + sb;      arith = 1; end
            4'h9: begin t = ua + ub + ci; st = sa + sb + ci; arith = 1; end
            4'hB: begin t = ua + 1;       st = sa + 1;       arith = 1; end
            4'h1, 4'hE: begin t = ua - ub; st = sa - sb; arith = 1; is_sub = 1; end
            4'hA: begin t = ua - ub - ci; st = sa - sb - ci; arith = 1; is_sub = 1; end
            4'hC: begin t = ua - 1;       st = sa - 1;       arith = 1; is_sub = 1; end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'hD: r = b;
            4'h6: begin
                r = a;
                for (int i = 0; i < int'(b[3:0]); i++) begin c = r[15]; r = r << 1; end
            end
            4'h7: begin
                r = a;
                for (int i = 0; i < int'(b[3:0]); i++) begin c = r[0]; r = r >> 1; end
            end
            4'h8: begin
                r = a;
                for (int i = 0; i < int'(b[3:0]); i++) begin c = r[0]; r = {r[15], r[15:1]}; end
            end
            default: return '0;
        endcase
        if (arith) begin
            r    = t[15:0];
            c    = is_sub ? (t < 0) : (t > 65535);
            e.vf = (st > 32767) || (st < -32768);
        end
        e.cf  = c;
        e.zf  = (r == 16'h0000);
        e.nf  = r[15];
        e.res = (op == 4'hE) ? a : r;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, then check hand-over, stall stability and
    // acceptance. use_x selects an explicit expected value instead of the model.
    task automatic step(input bit v, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input bit ordy, input bit en,
                        input bit use_x, input exp_t x);
        exp_t obs, e;
        @(negedge clk);
        ifc.In_Valid  = v;
        ifc.Opcode    = op;
        ifc.Data_A    = a;
        ifc.Data_B    = b;
        ifc.Out_Ready = ordy;
        ifc.Enable    = en;
        #1;
        obs = {ifc.Results, ifc.CF, ifc.ZF, ifc.NF, ifc.VF};
        if (!en) chk("enable_block", 64'(ifc.In_Ready), 64'd0);
        if (ifc.Out_Valid && !ifc.Out_Ready) begin
            if (held_v) chk("stall_hold", 64'(obs), 64'(held));
            held   = obs;
            held_v = 1'b1;
        end else begin
            held_v = 1'b0;
        end
        if (ifc.Out_Valid && ifc.Out_Ready) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output observed=%0h expected=none", obs);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk($sformatf("result op=%0h", e.res), 64'(obs), 64'(e));
            end
        end
        if (ifc.In_Valid && ifc.In_Ready) begin
            e = use_x ? x : model(op, a, b, model_cf);
            model_cf = e.cf;
            sb_q.push_back(e);
            acc_cnt++;
            $display("accept op=%0h a=%04h b=%04h exp_res=%04h", op, a, b, e.res);
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 4'h0, 16'h0, 16'h0, ordy, 1'b1, 1'b0, '0);
    endtask

    task automatic opx(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input exp_t x);
        step(1'b1, op, a, b, 1'b1, 1'b1, 1'b1, x);
    endtask

    task automatic drain();
        int i = 0;
        while (sb_q.size() != 0 && i < 40) begin
            idle(1'b1);
            i++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        ifc.Enable    = 1'b1;
        ifc.In_Valid  = 1'b0;
        ifc.Data_A    = '0;
        ifc.Data_B    = '0;
        ifc.Opcode    = '0;
        ifc.Out_Ready = 1'b1;
        rst_n = 1'b0;
        #3;
        chk("reset_outputs", 64'({ifc.Out_Valid, ifc.Results, ifc.CF, ifc.ZF, ifc.NF, ifc.VF}), 64'd0);
        chk("reset_in_ready", 64'(ifc.In_Ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry out, latency of two edges
        opx(4'h0, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
        idle(1'b1);
        chk("latency_s1", 64'(ifc.Out_Valid), 64'd0);
        idle(1'b1);
        chk("latency_s2", 64'(ifc.Out_Valid), 64'd1);

        // SUB overflow and CMP
        opx(4'h1, 16'h8000, 16'h0001, '{16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1});
        opx(4'hE, 16'h0003, 16'h0005, '{16'h0003, 1'b1, 1'b0, 1'b1, 1'b0});
        drain();

        // ADD then ADC chained without a bubble
        opx(4'h0, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
        opx(4'h9, 16'h0000, 16'h0000, '{16'h0001, 1'b0, 1'b0, 1'b0, 1'b0});
        idle(1'b1);
        chk("chain_first_valid", 64'(ifc.Out_Valid), 64'd1);
        idle(1'b1);
        chk("chain_second_valid", 64'(ifc.Out_Valid), 64'd1);

        // Shifts and the reserved opcode
        opx(4'h8, 16'h8001, 16'h0001, '{16'hC000, 1'b1, 1'b0, 1'b1, 1'b0});
        opx(4'h6, 16'h1234, 16'h0000, '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b0});
        opx(4'hF, 16'h1234, 16'h5678, '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0});
        drain();

        // Enable low blocks acceptance
        acc0 = acc_cnt;
        step(1'b1, 4'h0, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 4'h0, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, '0);
        idle(1'b1);
        idle(1'b1);
        chk("enable_accepts", 64'(acc_cnt - acc0), 64'd0);
        chk("enable_no_output", 64'(ifc.Out_Valid), 64'd0);

        // Back-pressure: five stalled cycles with continuous In_Valid
        acc0 = acc_cnt;
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'h0, 16'(i * 16'h1111), 16'h0001, 1'b0, 1'b1, 1'b0, '0);
        chk("stall_accepts", 64'(acc_cnt - acc0), 64'd2);
        chk("stall_in_ready", 64'(ifc.In_Ready), 64'd0);
        chk("stall_out_valid", 64'(ifc.Out_Valid), 64'd1);
        drain();

        // Random mix with random back-pressure and enable
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 16'($urandom), 16'($urandom), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 9) != 0), 1'b0, '0);
        drain();

        // Reset with two ops in flight
        step(1'b1, 4'h0, 16'h0001, 16'h0002, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 4'h1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, '0);
        @(posedge clk);
        #2;
        ifc.In_Valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 64'({ifc.Out_Valid, ifc.Results, ifc.CF, ifc.ZF, ifc.NF, ifc.VF}), 64'd0);
        chk("midrst_in_ready", 64'(ifc.In_Ready), 64'd0);
        sb_q.delete();
        model_cf = 1'b0;
        held_v   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(ifc.In_Ready), 64'd1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("post_rst_no_stale", 64'(ifc.Out_Valid), 64'd0);
        // carry-in must be cleared by reset
        opx(4'h9, 16'h0000, 16'h0000, '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_pipelined.md
ALU_PIPELINED -- requirements
Module: alu_pipelined

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal range 4..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), number of Data_B LSBs used as shift amount.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-low.
REQ-005 Enable  input  1  block enable; 0 blocks new acceptance, in-flight ops still drain.
REQ-006 In_Valid  input  1  Data_A/Data_B/Opcode valid this cycle.
REQ-007 In_Ready  output  1  block can accept an operation this cycle.
REQ-008 Data_A  input  WIDTH  operand A.
REQ-009 Data_B  input  WIDTH  operand B, or shift amount in B[SHW-1:0].
REQ-010 Opcode  input  4  operation select.
REQ-011 Out_Valid  output  1  Results and flags valid.
REQ-012 Out_Ready  input  1  downstream accepts the result this cycle.
REQ-013 Results  output  WIDTH  registered result.
REQ-014 CF, ZF, NF, VF  output  1 each  carry/borrow, zero, negative (MSB), signed overflow; registered with Results.

Function
REQ-015 Two register stages: S1 captures operands; S2 holds the executed result and flags; latency from accept to Out_Valid is exactly 2 cycles without stall.
REQ-016 Accept: In_Valid && In_Ready at a rising edge; throughput 1 op/cycle.
REQ-017 S2 advances when !Out_Valid || Out_Ready; S1 advances when S1 holds an op and S2 advances.
REQ-018 In_Ready = Enable && (!S1_valid || S1 advances); combinational, no dependence on In_Valid.
REQ-019 While Out_Valid && !Out_Ready, Results and all flags hold stable; no op is lost or duplicated.
REQ-020 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR logical, 8 SRA, 9 ADC (A+B+CF), A SBB (A-B-CF), B INC A, C DEC A, D PASS B, E CMP, F reserved.
REQ-021 Arithmetic is WIDTH bits modulo 2^WIDTH; CF = carry out for ADD/ADC/INC, CF = borrow (1 when unsigned minuend < subtrahend + borrow-in) for SUB/SBB/DEC/CMP.
REQ-022 VF set on signed overflow for ops 0,1,9,A,B,C,E; VF = 0 for all others.
REQ-023 Shifts use B[SHW-1:0]; CF = last bit shifted out; shift amount 0 gives Results = A, CF = 0.
REQ-024 Logic ops, NOT, PASS: CF = 0, VF = 0.
REQ-025 ZF = (Results == 0), NF = Results[WIDTH-1] for every op except CMP.
REQ-026 CMP: Results = A; CF/ZF/NF/VF computed from A-B.
REQ-027 Opcode F: Results = 0, all flags 0, Out_Valid still asserted (op retires).
REQ-028 ADC/SBB carry-in = CF of the op most recently moved into S2 (back-to-back chaining with no bubble); after reset carry-in = 0.
REQ-029 Enable deasserted: In_Ready = 0 next evaluation; ops already in S1/S2 complete normally.

Reset
REQ-030 RST low asynchronously clears S1/S2 valid, Out_Valid, Results, CF, ZF, NF, VF and carry-in state to 0 and forces In_Ready = 0.
REQ-031 Reset mid-operation discards all in-flight ops; first acceptance possible on the first rising edge after RST high with Enable = 1.

Verification (WIDTH = 16)
REQ-032 ADD A=0xFFFF B=0x0001, Out_Ready=1 -> 2 cycles later Out_Valid=1, Results=0x0000, CF=1, ZF=1, NF=0, VF=0.
REQ-033 SUB A=0x8000 B=0x0001 -> Results=0x7FFF, CF=0, VF=1, NF=0; CMP A=0x0003 B=0x0005 -> Results=0x0003, CF=1, NF=1, ZF=0.
REQ-034 Back-to-back ADD 0xFFFF+0x0001 then ADC 0x0000+0x0000 -> results 0x0000 (CF=1) then 0x0001 (CF=0) on consecutive cycles.
REQ-035 Out_Ready=0 for 5 cycles with In_Valid=1 continuous -> exactly 2 ops accepted, In_Ready=0 thereafter, first result held; Out_Ready=1 -> all ops emerge in order, none lost.
REQ-036 SRA A=0x8001 B=0x0001 -> Results=0xC000, CF=1, NF=1; SHL A=0x1234 B=0x0000 -> Results=0x1234, CF=0.
REQ-037 RST low while 2 ops in flight -> Out_Valid, Results, flags 0 immediately; after RST high no stale result appears.
